regbank_write_sched: RTL and testbench

//   Sole owner of the 32x8 register bank write port (write/write_register/write_data).

---
 rtl/regbank_write_sched_pkg.sv | 19 +
 rtl/regbank_write_sched_if.sv | 27 ++
 rtl/regbank_write_sched_arb.sv | 34 +++
 rtl/regbank_write_sched.sv | 82 ++++++++
 tb/tb_regbank_write_sched.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/regbank_write_sched_pkg.sv
// rtl/regbank_write_sched_pkg.sv - shared widths, state and requester encodings for the write scheduler
package regbank_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int IDX_W    = $clog2(NUM_REGS) + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

endpackage

// File: rtl/regbank_write_sched_if.sv
// rtl/regbank_write_sched_if.sv - write-back request/grant handshakes and register bank write port
interface regbank_write_sched_if;
    import regbank_pkg::*;

    logic              alu_req;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_gnt;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_gnt;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              init_done;

    modport master (
        output alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data,
        input  alu_gnt, mem_gnt, rf_write, rf_write_reg, rf_write_data, init_done
    );

    modport slave (
        input  alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data,
        output alu_gnt, mem_gnt, rf_write, rf_write_reg, rf_write_data, init_done
    );
endinterface

// File: rtl/regbank_write_sched_arb.sv
// rtl/regbank_write_sched_arb.sv - two-way round-robin arbiter holding the last-granted flop
module rr_arb2
    import regbank_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    req_id_t last;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11)
                gnt = (last == REQ_MEM) ? 2'b01 : 2'b10;
            else
                gnt = req;
        end
    end

    // Reset to MEM so ALU wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last <= REQ_MEM;
        else if (gnt[0])
            last <= REQ_ALU;
        else if (gnt[1])
            last <= REQ_MEM;
    end

endmodule

// File: rtl/regbank_write_sched.sv
// rtl/regbank_write_sched.sv - clears the register bank on reset/clear, then schedules ALU/MEM write-backs
module regbank_write_sched
    import regbank_pkg::*;
#(
    parameter bit ZERO_LOCK = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    regbank_write_sched_if.slave  bus
);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              wr_nxt;
    logic [ADDR_W-1:0] reg_nxt, sel_addr;
    logic [DATA_W-1:0] data_nxt, sel_data;
    logic [1:0]        gnt;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({bus.mem_req, bus.alu_req}),
        .enable  ((state == ST_RUN) && !clear),
        .gnt     (gnt)
    );

    assign bus.alu_gnt   = gnt[0];
    assign bus.mem_gnt   = gnt[1];
    assign bus.init_done = (state == ST_RUN);
    assign sel_addr      = gnt[1] ? bus.mem_addr : bus.alu_addr;
    assign sel_data      = gnt[1] ? bus.mem_data : bus.alu_data;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_nxt    = 1'b0;
        reg_nxt   = bus.rf_write_reg;
        data_nxt  = bus.rf_write_data;
        if (clear) begin
            state_nxt = ST_INIT;
            idx_nxt   = '0;
        end else begin
            case (state)
                ST_INIT: begin
                    wr_nxt   = 1'b1;
                    reg_nxt  = ADDR_W'(idx);
                    data_nxt = '0;
                    idx_nxt  = idx + 1'b1;
                    if (idx == IDX_W'(NUM_REGS - 1))
                        state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    // A locked register-0 write is still granted (consumed) but never strobed
                    if (|gnt && !(ZERO_LOCK && sel_addr == '0)) begin
                        wr_nxt   = 1'b1;
                        reg_nxt  = sel_addr;
                        data_nxt = sel_data;
                    end
                end
                default: state_nxt = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_INIT;
            idx               <= '0;
            bus.rf_write      <= 1'b0;
            bus.rf_write_reg  <= '0;
            bus.rf_write_data <= '0;
        end else begin
            state             <= state_nxt;
            idx               <= idx_nxt;
            bus.rf_write      <= wr_nxt;
            bus.rf_write_reg  <= reg_nxt;
            bus.rf_write_data <= data_nxt;
        end
    end

endmodule

// File: tb/tb_regbank_write_sched.sv
// tb/tb_regbank_write_sched.sv - directed checks of init walk, arbitration, zero lock, clear and reset
module tb_regbank_write_sched;
    import regbank_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    int   checks = 0;
    int   passes = 0;

    regbank_write_sched_if bus ();

    regbank_write_sched #(.ZERO_LOCK(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.alu_req = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_req = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_write", 32'(bus.rf_write), 32'd0);
        chk("rst_reg",   32'(bus.rf_write_reg), 32'd0);
        chk("rst_data",  32'(bus.rf_write_data), 32'd0);
        chk("rst_done",  32'(bus.init_done), 32'd0);
        chk("rst_agnt",  32'(bus.alu_gnt), 32'd0);
        chk("rst_mgnt",  32'(bus.mem_gnt), 32'd0);

        // Init walk with no requests
        reset_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("walk_write", 32'(bus.rf_write), 32'd1);
            chk("walk_reg",   32'(bus.rf_write_reg), 32'(k - 1));
            chk("walk_data",  32'(bus.rf_write_data), 32'd0);
            chk("walk_done",  32'(bus.init_done), (k == 32) ? 32'd1 : 32'd0);
        end
        step();
        chk("idle_write", 32'(bus.rf_write), 32'd0);
        chk("idle_done",  32'(bus.init_done), 32'd1);
        chk("idle_reg",   32'(bus.rf_write_reg), 32'd31);

        // Reset mid-walk at idx 17
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (18) step();
        chk("mid_reg17", 32'(bus.rf_write_reg), 32'd17);
        reset_n = 1'b0;
        bus.alu_req = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 8'hA5;
        #1;
        chk("async_write", 32'(bus.rf_write), 32'd0);
        chk("async_reg",   32'(bus.rf_write_reg), 32'd0);
        chk("async_done",  32'(bus.init_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU held through the walk: granted only in first RUN cycle
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("rewalk_reg", 32'(bus.rf_write_reg), 32'(k - 1));
            chk("rewalk_agnt", 32'(bus.alu_gnt), (k == 32) ? 32'd1 : 32'd0);
        end
        step();
        chk("alu_write", 32'(bus.rf_write), 32'd1);
        chk("alu_reg",   32'(bus.rf_write_reg), 32'd5);
        chk("alu_data",  32'(bus.rf_write_data), 32'hA5);
        bus.alu_req = 1'b0;
        #1;
        chk("alu_drop_gnt", 32'(bus.alu_gnt), 32'd0);
        step();
        chk("nogrant_write", 32'(bus.rf_write), 32'd0);
        chk("nogrant_reg",   32'(bus.rf_write_reg), 32'd5);
        chk("nogrant_data",  32'(bus.rf_write_data), 32'hA5);

        // Zero lock: MEM to reg 0 is granted but not written
        bus.mem_req = 1'b1; bus.mem_addr = 5'd0; bus.mem_data = 8'hFF;
        #1;
        chk("zl_mgnt", 32'(bus.mem_gnt), 32'd1);
        chk("zl_agnt", 32'(bus.alu_gnt), 32'd0);
        step();
        chk("zl_write", 32'(bus.rf_write), 32'd0);
        bus.mem_req = 1'b0;

        // Both requesting: ALU first (last was MEM), then alternate
        bus.alu_req = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 8'h11;
        bus.mem_req = 1'b1; bus.mem_addr = 5'd4; bus.mem_data = 8'h22;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_agnt", 32'(bus.alu_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_mgnt", 32'(bus.mem_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            chk("rr_write", 32'(bus.rf_write), 32'd1);
            chk("rr_reg",   32'(bus.rf_write_reg), (i % 2 == 0) ? 32'd3 : 32'd4);
            chk("rr_data",  32'(bus.rf_write_data), (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        bus.alu_req = 1'b0; bus.mem_req = 1'b0;
        step();
        chk("rr_end_write", 32'(bus.rf_write), 32'd0);

        // Clear during RUN with ALU pending
        bus.alu_req = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 8'h5A;
        clear = 1'b1;
        #1;
        chk("clr_agnt", 32'(bus.alu_gnt), 32'd0);
        chk("clr_done_before", 32'(bus.init_done), 32'd1);
        step();
        chk("clr_done_after", 32'(bus.init_done), 32'd0);
        chk("clr_write", 32'(bus.rf_write), 32'd0);
        clear = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("clr_walk_write", 32'(bus.rf_write), 32'd1);
            chk("clr_walk_reg",   32'(bus.rf_write_reg), 32'(k - 1));
            chk("clr_walk_agnt",  32'(bus.alu_gnt), (k == 32) ? 32'd1 : 32'd0);
        end
        step();
        chk("clr_alu_write", 32'(bus.rf_write), 32'd1);
        chk("clr_alu_reg",   32'(bus.rf_write_reg), 32'd9);
        chk("clr_alu_data",  32'(bus.rf_write_data), 32'h5A);
        bus.alu_req = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
